// File: rtl/dds_core_param.sv
// Parametrised DDS core: phase accumulator, phase offset, ROM addressing and amplitude scaling.
// Runtime config via valid/ready with immediate or wrap-aligned apply, plus optional linear sweep.
module dds_core_param #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AMP_W  = 8
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic                    cfg_sync,
  input  logic [ACC_W-1:0]        cfg_freq,
  input  logic [ACC_W-1:0]        cfg_phase,
  input  logic [SEL_W-1:0]        cfg_sel,
  input  logic [AMP_W-1:0]        cfg_amp,
  input  logic                    sweep_en,
  input  logic [ACC_W-1:0]        sweep_step,
  input  logic [ACC_W-1:0]        sweep_stop,
  output logic [SEL_W+ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [DATA_W-1:0]       wave_out,
  output logic                    wave_valid,
  output logic                    wrap,
  output logic                    sweep_done
);

  localparam logic [DATA_W-1:0] MidVal = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [AMP_W-1:0]  AmpOne = '1;
  localparam int unsigned       ProdW  = DATA_W + AMP_W + 2;

  logic [ACC_W-1:0]        acc_q, acc_d, freq_q, freq_d, phase_q, phase_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [AMP_W-1:0]        amp_q, amp_d;
  logic [ACC_W-1:0]        sh_freq_q, sh_freq_d, sh_phase_q, sh_phase_d;
  logic [SEL_W-1:0]        sh_sel_q, sh_sel_d;
  logic [AMP_W-1:0]        sh_amp_q, sh_amp_d;
  logic                    sh_sync_q, sh_sync_d, pend_q, pend_d;
  logic                    sweep_act_q, sweep_act_d, sweep_done_q, sweep_done_d;
  logic                    wrap_q, wrap_d;
  logic [SEL_W+ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0]       wave_q, wave_d;
  logic [2:0]              vld_q, vld_d;

  logic [ACC_W:0]          acc_sum, sweep_sum;
  logic [ADDR_W-1:0]       ph_idx;
  logic                    cfg_fire, apply, sweep_tick, sweep_hit;
  logic signed [DATA_W:0]  samp_s;
  logic signed [ProdW-1:0] prod;
  logic [DATA_W-1:0]       scaled;

  always_comb begin
    acc_sum    = {1'b0, acc_q} + {1'b0, freq_q};
    sweep_sum  = {1'b0, freq_q} + {1'b0, sweep_step};
    sweep_hit  = sweep_sum >= {1'b0, sweep_stop};
    ph_idx     = ADDR_W'((acc_q + phase_q) >> (ACC_W - ADDR_W));
    cfg_fire   = cfg_valid && !pend_q;
    // Wrap-aligned configs wait for a wrap pulse seen while running.
    apply      = pend_q && (!sh_sync_q || (wrap_q && enable));
    // A config applied on the same wrap takes priority over the sweep step.
    sweep_tick = wrap_q && sweep_act_q && sweep_en && (sweep_step != '0) && !apply;
    samp_s     = $signed({1'b0, rom_data}) - $signed({1'b0, MidVal});
    prod       = ProdW'(samp_s) * ProdW'($signed({1'b0, amp_q}));
    scaled     = (amp_q == AmpOne) ? rom_data : MidVal + DATA_W'(prod >>> AMP_W);
  end

  always_comb begin
    acc_d        = acc_q;
    freq_d       = freq_q;
    phase_d      = phase_q;
    sel_d        = sel_q;
    amp_d        = amp_q;
    sh_freq_d    = sh_freq_q;
    sh_phase_d   = sh_phase_q;
    sh_sel_d     = sh_sel_q;
    sh_amp_d     = sh_amp_q;
    sh_sync_d    = sh_sync_q;
    pend_d       = pend_q;
    sweep_act_d  = sweep_act_q;
    sweep_done_d = 1'b0;
    wrap_d       = 1'b0;
    rom_addr_d   = rom_addr_q;
    wave_d       = wave_q;
    vld_d        = {vld_q[1:0], enable};

    if (enable) begin
      acc_d      = acc_sum[ACC_W-1:0];
      wrap_d     = acc_sum[ACC_W];
      rom_addr_d = {sel_q, ph_idx};
    end
    if (vld_q[1]) begin
      wave_d = scaled;
    end

    if (cfg_fire) begin
      sh_freq_d  = cfg_freq;
      sh_phase_d = cfg_phase;
      sh_sel_d   = cfg_sel;
      sh_amp_d   = cfg_amp;
      sh_sync_d  = cfg_sync;
      pend_d     = 1'b1;
    end

    if (apply) begin
      freq_d      = sh_freq_q;
      phase_d     = sh_phase_q;
      sel_d       = sh_sel_q;
      amp_d       = sh_amp_q;
      pend_d      = 1'b0;
      sweep_act_d = sweep_en;
    end else if (sweep_tick) begin
      if (sweep_hit) begin
        freq_d       = sweep_stop;
        sweep_done_d = 1'b1;
        sweep_act_d  = 1'b0;
      end else begin
        freq_d = sweep_sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      acc_q        <= '0;
      freq_q       <= '0;
      phase_q      <= '0;
      sel_q        <= '0;
      amp_q        <= '0;
      sh_freq_q    <= '0;
      sh_phase_q   <= '0;
      sh_sel_q     <= '0;
      sh_amp_q     <= '0;
      sh_sync_q    <= 1'b0;
      pend_q       <= 1'b0;
      sweep_act_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      wrap_q       <= 1'b0;
      rom_addr_q   <= '0;
      wave_q       <= MidVal;
      vld_q        <= '0;
    end else begin
      acc_q        <= acc_d;
      freq_q       <= freq_d;
      phase_q      <= phase_d;
      sel_q        <= sel_d;
      amp_q        <= amp_d;
      sh_freq_q    <= sh_freq_d;
      sh_phase_q   <= sh_phase_d;
      sh_sel_q     <= sh_sel_d;
      sh_amp_q     <= sh_amp_d;
      sh_sync_q    <= sh_sync_d;
      pend_q       <= pend_d;
      sweep_act_q  <= sweep_act_d;
      sweep_done_q <= sweep_done_d;
      wrap_q       <= wrap_d;
      rom_addr_q   <= rom_addr_d;
      wave_q       <= wave_d;
      vld_q        <= vld_d;
    end
  end

  assign cfg_ready  = ~pend_q;
  assign rom_addr   = rom_addr_q;
  assign wave_out   = wave_q;
  assign wave_valid = vld_q[2];
  assign wrap       = wrap_q;
  assign sweep_done = sweep_done_q;

endmodule
